// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Performs MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU at width XLEN.
// Only one operation is in flight at a time. Multiplies use radix-2 shift-add
// on the operand magnitudes, and divides use restoring division on the
// magnitudes. Signs are applied on the final iteration. Division by zero and
// signed overflow are resolved when the request is accepted.
//
// Optional build macro MULDIV_FAST_MUL_EN: when it is defined, multiplies use
// one combinational signed (XLEN+1)x(XLEN+1) product and finish one cycle
// after accept. Divides are the same in both builds.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             abort the in-flight operation and any pending response
//   req_valid/ready   request handshake
//   req_op            funct3 operation code
//   req_a, req_b      rs1 / rs2 operands
//   req_tag           opaque tag returned with the result
//   resp_valid/ready  response handshake
//   resp_data         result
//   resp_tag          tag of the request that produced resp_data
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic [TAG_W-1:0] resp_tag
);

   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op;
   logic                sign_a;
   logic                sign_b;
   logic [XLEN-1:0]     opnd;
   logic [2*XLEN-1:0]   acc;

   function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
      return c ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_wide(input logic c, input logic [2*XLEN-1:0] v);
      return c ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] pick_result(input logic [2:0] f,
                                                   input logic [2*XLEN-1:0] prod,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] rem);
      case (f)
         3'b000:                 return prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         return quo;
         default:                return rem;
      endcase
   endfunction

   // Request decode. MULHSU treats only rs1 as signed. MULHU, DIVU and REMU
   // treat both operands as unsigned.
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, special, accept;
   logic [XLEN-1:0] special_res;

   assign a_signed = req_op[2] ? ~req_op[0] : (req_op[1:0] != 2'b11);
   assign b_signed = req_op[2] ? ~req_op[0] : ~req_op[1];
   assign a_neg    = a_signed & req_a[XLEN-1];
   assign b_neg    = b_signed & req_b[XLEN-1];
   assign a_mag    = neg_if(a_neg, req_a);
   assign b_mag    = neg_if(b_neg, req_b);

   assign div_zero = req_op[2] & (req_b == '0);
   assign div_ovf  = req_op[2] & ~req_op[0] & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == '1);
   assign special  = div_zero | div_ovf;
   // req_op[1] selects the remainder forms.
   assign special_res = div_zero ? (req_op[1] ? req_a : '1)
                                 : (req_op[1] ? '0 : req_a);

   assign accept = (state == IDLE) & req_valid & ~flush;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]          fast_res;

   assign fast_a    = $signed({a_signed & req_a[XLEN-1], req_a});
   assign fast_b    = $signed({b_signed & req_b[XLEN-1], req_b});
   assign fast_prod = $signed({{(XLEN-1){fast_a[XLEN]}}, fast_a}) *
                      $signed({{(XLEN-1){fast_b[XLEN]}}, fast_b});
   assign fast_res  = pick_result(req_op, fast_prod, '0, '0);
`endif

   // One iteration step.
   // Multiply: acc = {partial high, multiplier}. The register shifts right,
   //           and each shift retires one multiplier bit.
   // Divide:   acc = {remainder, dividend/quotient}. The register shifts left,
   //           and each shift inserts one quotient bit.
   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff, fix_res;
   logic [2*XLEN-1:0] mul_next, div_next, acc_next;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_shift = acc[2*XLEN-1:XLEN-1];
   assign div_ge    = div_shift >= {1'b0, opnd};
   // The difference is only kept when div_ge is set. It is then smaller than
   // the divisor, so the low XLEN bits hold all of it.
   assign div_diff  = div_shift[XLEN-1:0] - opnd;
   assign div_next  = {div_ge ? div_diff : div_shift[XLEN-1:0], acc[XLEN-2:0], div_ge};
   assign acc_next  = op[2] ? div_next : mul_next;

   // Sign fix-up is applied to the last step's output as the unit enters DONE.
   assign fix_res = pick_result(op,
                                neg_if_wide(sign_a ^ sign_b, acc_next),
                                neg_if(sign_a ^ sign_b, acc_next[XLEN-1:0]),
                                neg_if(sign_a, acc_next[2*XLEN-1:XLEN]));

   // Operand and datapath registers. These need no reset: they are always
   // loaded at accept before they are used.
   always_ff @(posedge clk) begin
      if (accept) begin
         op     <= req_op;
         sign_a <= a_neg;
         sign_b <= b_neg;
         if (req_op[2]) begin
            opnd <= b_mag;
            acc  <= {{XLEN{1'b0}}, a_mag};
         end else begin
            opnd <= a_mag;
            acc  <= {{XLEN{1'b0}}, b_mag};
         end
      end else if (state == BUSY) begin
         acc <= acc_next;
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_tag   <= '0;
      end else if (flush) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  resp_tag  <= req_tag;
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  if (special) begin
                     resp_data  <= special_res;
                     resp_valid <= 1'b1;
                     state      <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!req_op[2]) begin
                     resp_data  <= fast_res;
                     resp_valid <= 1'b1;
                     state      <= DONE;
`endif
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt == CNT_W'(XLEN-1)) begin
                  resp_data  <= fix_res;
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed bench for muldiv_unit (XLEN=32).
// Expected results come from a reference model that uses plain 64-bit
// arithmetic on the RV32M rules. Expected latencies come from the op class.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_tag;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, p;
      logic [63:0] up;
      int          ia, ib, r;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = (sa * sb) >>> 32; return p[31:0]; end
         3'd2: begin p = (sa * ub) >>> 32; return p[31:0]; end
         3'd3: begin up = 64'(ua) * 64'(ub); return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            r = ia / ib; return r;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            r = ia % ib; return r;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) return 1;
`endif
      return 33;
   endfunction

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("req_ready_wait", req_ready, 1);
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      wait_ready();
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      @(posedge clk); #1;
      // Scramble the inputs after accept: the result must not depend on them.
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = 5'($urandom);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold, input logic [31:0] exp);
      int k;
      send(op, a, b, tag);
      k = 0;
      while (!resp_valid && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency", k + 1, exp_latency(op, a, b));
      chk("resp_data", resp_data, exp);
      chk("resp_tag", resp_tag, tag);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, exp);
         chk("hold_tag", resp_tag, tag);
         chk("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("post_hs_valid", resp_valid, 0);
      chk("post_hs_ready", req_ready, 1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic        seen;
      logic [2:0]  op;
      logic [31:0] a, b;
      rst_n      = 1'b0;
      flush      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      req_tag    = '0;
      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_tag", resp_tag, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases with fixed expected values.
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 32'hFFFF_FFEB);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, 32'h4000_0000);
      run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 32'h4000_0000);
      run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 0, 32'hFFFF_FFFF);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 32'hFFFF_FFFD);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFF);
      run_op(3'b101, 32'd100, 32'd7, 5'd7, 0, 32'd14);
      run_op(3'b111, 32'd100, 32'd7, 5'd8, 0, 32'd2);
      run_op(3'b100, 32'd5, 32'd0, 5'd10, 0, 32'hFFFF_FFFF);
      run_op(3'b111, 32'd5, 32'd0, 5'd11, 0, 32'd5);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 32'h8000_0000);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 32'd0);
      // Back-pressure: hold the response for 10 cycles.
      run_op(3'b101, 32'd100, 32'd7, 5'd9, 10, 32'd14);

      // Flush partway through a divide. A request in the same cycle is not taken.
      send(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd21);
      repeat (9) @(posedge clk);
      #1;
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = 3'b101;
      req_a     = 32'd50;
      req_b     = 32'd5;
      req_tag   = 5'd3;
      @(posedge clk); #1;
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("flush_valid", resp_valid, 0);
      chk("flush_ready", req_ready, 1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      chk("flush_no_resp", seen, 0);
      chk("flush_idle", req_ready, 1);
      run_op(3'b101, 32'd9, 32'd3, 5'd4, 0, 32'd3);

      // Flush in DONE together with resp_ready drops the response.
      send(3'b100, 32'd5, 32'd0, 5'd14);
      flush      = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      flush      = 1'b0;
      resp_ready = 1'b0;
      chk("flush_done_valid", resp_valid, 0);
      chk("flush_done_ready", req_ready, 1);

      // Randomized operations checked against the reference model.
      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), ref_model(op, a, b));
      end

      // Asynchronous reset in the middle of an operation.
      run_op(3'b101, 32'd1000, 32'd10, 5'd17, 0, 32'd100);
      send(3'b100, 32'd77, 32'd5, 5'd19);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_req_ready", req_ready, 1);
      chk("arst_resp_valid", resp_valid, 0);
      chk("arst_resp_data", resp_data, 0);
      chk("arst_resp_tag", resp_tag, 0);
      #6 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 0, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised iterative multiply/divide unit for the execute stage.
- Implements all eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width.
- Uses a valid/ready request/response handshake, a tag passthrough and a pipeline flush.
- Sits beside the single-cycle ALU; the EX stage stalls on it for long-latency M-extension ops.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.
- TAG_W, 5, width of opaque tag (destination register index) carried from request to response.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  kill the in-flight operation and any undelivered response.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  XLEN  rs1 operand.
- req_b  in  XLEN  rs2 operand.
- req_tag  in  TAG_W  tag.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  XLEN  result.
- resp_tag  out  TAG_W  tag of the accepted request.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - req_ready=1.
  - On req_valid, latch op, operands, tag and operand signs, then go to BUSY.
  - Special cases go to DONE directly.
- Special cases (result computed at accept):
  - DIV/DIVU with b=0: quotient all-ones; REM/REMU with b=0: result = a.
  - DIV with a=most-negative and b=−1: result = a; REM in that case: result 0.
- BUSY
  - XLEN-step iteration counter, counting 0..XLEN−1.
  - Multiply: radix-2 shift-add on operand magnitudes into a 2·XLEN product register.
  - Divide: restoring, unsigned on magnitudes; quotient and remainder registers.
  - Transition to DONE when counter = XLEN−1.
- Sign fix-up on the transition into DONE:
  - Multiply: negate the product if signs differ. MULHSU treats only a as signed; MULHU and DIVU/REMU are fully unsigned.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of a.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder.
- DONE
  - resp_valid=1; resp_data and resp_tag held stable until handshake.
  - On resp_valid & resp_ready, go to IDLE.
- One operation in flight; req_ready=0 in BUSY and DONE.
- All arithmetic is internally XLEN+1 bits for the divider subtract; overflow bits are discarded.

## Timing
- Reset (async, rst_n=0): state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, counter=0.
- Request accepted at the rising edge where req_valid & req_ready.
- Iterative op: resp_valid rises exactly XLEN+1 cycles after the accepting edge (33 cycles for XLEN=32).
- Special-case op: resp_valid rises 1 cycle after the accepting edge.
- Response held until resp_ready; no timeout.
- After the response handshake edge, req_ready=1 in the next cycle; back-to-back throughput is one op per XLEN+2 cycles minimum.
- flush
  - Synchronous; has priority over everything.
  - At the next edge: state IDLE, resp_valid=0; a request presented in the same cycle as flush is not accepted.
- flush during DONE with resp_ready=1 in the same cycle: the response is dropped (consumer must ignore it).
- rst_n deassertion mid-op: the operation is lost; the unit comes up in IDLE.
- Operand changes after acceptance have no effect.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies use a single-cycle (XLEN+1)×(XLEN+1) signed combinational product and go IDLE→DONE.
  - resp_valid rises 1 cycle after accept for all four multiply ops.
  - Divides are unchanged.
- Undefined: multiplies are iterative as above (XLEN+1 cycles).
- Results are bit-identical in both builds.

## Test plan
All scenarios use XLEN=32.
- MUL a=7, b=−3 (0xFFFFFFFD), tag=5 -> resp_data=0xFFFFFFEB, resp_tag=5; resp_valid at cycle 33 after accept (cycle 1 with MULDIV_FAST_MUL_EN).
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=−7, b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2; each with 33-cycle latency.
- DIV a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=−1 -> 0x80000000; REM same -> 0. Each resp_valid 1 cycle after accept.
- Hold resp_ready=0 for 10 cycles in DONE -> resp_data/resp_tag stable, req_ready=0; then resp_ready=1 -> next cycle req_ready=1.
- flush asserted at cycle 10 of a DIV -> next cycle IDLE, no resp_valid ever for that tag. A new DIVU 9/3 then returns 3. Also pull rst_n low mid-op -> all outputs at their reset values immediately (asynchronously).
